// File: rtl/store_image_if.sv
// store_image_if: control, feature-map buffer and DMA write signals of store_image.
//   master : environment side (start request, buffer read data, DMA acknowledge)
//   slave  : store_image side (buffer read address, DMA block request, status)
interface store_image_if #(
    parameter int unsigned MEM_ADDR_SIZE  = 20,
    parameter int unsigned DATA_SIZE      = 16,
    parameter int unsigned BLOCK_SIZE     = 25,
    parameter int unsigned IMG_SIZE_WIDTH = 6
);
    localparam int unsigned BUF_AW  = 10;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned BLOCK_W = BLOCK_SIZE * DATA_SIZE;

    // Start control
    logic                      enable;
    logic [IMG_SIZE_WIDTH-1:0] imgSize;
    logic [MEM_ADDR_SIZE-1:0]  initialAddr;

    // Feature-map buffer read port
    logic [BUF_AW-1:0]         bufAddr;
    logic [DATA_SIZE-1:0]      bufData;

    // DMA write request
    logic                      dmaEnable;
    logic                      dmaAck;
    logic [MEM_ADDR_SIZE-1:0]  address;
    logic [BLOCK_W-1:0]        dmaData;
    logic [CNT_W-1:0]          dmaCount;

    // Status
    logic                      busy;
    logic                      done;

    modport master (
        output enable, imgSize, initialAddr, bufData, dmaAck,
        input  bufAddr, dmaEnable, address, dmaData, dmaCount, busy, done
    );

    modport slave (
        input  enable, imgSize, initialAddr, bufData, dmaAck,
        output bufAddr, dmaEnable, address, dmaData, dmaCount, busy, done
    );
endinterface

// File: rtl/store_image.sv
// store_image: copies an imgSize x imgSize feature map from the on-chip buffer to
// external memory as DMA blocks of up to BLOCK_SIZE words.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - store_image_if.slave: enable/imgSize/initialAddr start control,
//          bufAddr/bufData buffer read (data one cycle after address),
//          dmaEnable/dmaAck/address/dmaData/dmaCount block write, busy/done status
module store_image #(
    parameter int unsigned MEM_ADDR_SIZE  = 20,
    parameter int unsigned DATA_SIZE      = 16,
    parameter int unsigned BLOCK_SIZE     = 25,
    parameter int unsigned IMG_SIZE_WIDTH = 6
) (
    input  logic         clk,
    input  logic         rst,
    store_image_if.slave bus
);
    localparam int unsigned BUF_AW    = 10;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned N_W       = 11;
    localparam int unsigned PROD_W    = 2 * IMG_SIZE_WIDTH;
    localparam int unsigned MAX_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [N_W-1:0]                             n_q, n_d;       // total words
    logic [N_W-1:0]                             w_q, w_d;       // first word of current block
    logic [CNT_W-1:0]                           fcnt_q, fcnt_d; // FETCH cycle index
    logic [CNT_W-1:0]                           cnt_q, cnt_d;   // words in current block
    logic [BUF_AW-1:0]                          buf_addr_q, buf_addr_d;
    logic [MEM_ADDR_SIZE-1:0]                   addr_q, addr_d;
    logic [BLOCK_SIZE-1:0][DATA_SIZE-1:0]       data_q, data_d;
    logic                                       dma_en_q, dma_en_d;
    logic                                       busy_q, busy_d;
    logic                                       done_q, done_d;

    logic [PROD_W-1:0] n_full_c;
    logic [N_W-1:0]    n_start_c;
    logic [N_W-1:0]    w_next_c;
    logic [CNT_W-1:0]  slot_c;

    // Words left from w, limited to one block
    function automatic logic [CNT_W-1:0] blk_cnt(input logic [N_W-1:0] n,
                                                 input logic [N_W-1:0] w);
        logic [N_W-1:0] rem;
        rem = n - w;
        return (rem > N_W'(BLOCK_SIZE)) ? CNT_W'(BLOCK_SIZE) : rem[CNT_W-1:0];
    endfunction

    // Word count at full product width, clipped to the buffer size
    always_comb begin
        n_full_c  = PROD_W'(bus.imgSize) * PROD_W'(bus.imgSize);
        n_start_c = (n_full_c > PROD_W'(MAX_WORDS)) ? N_W'(MAX_WORDS) : N_W'(n_full_c);
        w_next_c  = w_q + N_W'(cnt_q);
        slot_c    = fcnt_q - CNT_W'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = (n_start_c == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (fcnt_q == cnt_q) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.dmaAck) begin
                    state_d = (w_next_c < n_q) ? FETCH : DONE;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs
    always_comb begin
        n_d        = n_q;
        w_d        = w_q;
        fcnt_d     = fcnt_q;
        cnt_d      = cnt_q;
        buf_addr_d = buf_addr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        dma_en_d   = dma_en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    n_d    = n_start_c;
                    w_d    = '0;
                    addr_d = bus.initialAddr;
                    busy_d = 1'b1;
                    if (n_start_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d      = blk_cnt(n_start_c, '0);
                        fcnt_d     = '0;
                        buf_addr_d = '0;
                        data_d     = '0;
                    end
                end
            end
            FETCH: begin
                // Data for address issued in cycle k arrives in cycle k+1
                if (fcnt_q != '0) begin
                    data_d[slot_c] = bus.bufData;
                end
                if (fcnt_q == cnt_q) begin
                    dma_en_d = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + CNT_W'(1);
                    if ((fcnt_q + CNT_W'(1)) < cnt_q) begin
                        buf_addr_d = buf_addr_q + BUF_AW'(1);
                    end
                end
            end
            WRITE: begin
                if (bus.dmaAck) begin
                    dma_en_d = 1'b0;
                    addr_d   = addr_q + MEM_ADDR_SIZE'(BLOCK_SIZE);
                    w_d      = w_next_c;
                    if (w_next_c < n_q) begin
                        cnt_d      = blk_cnt(n_q, w_next_c);
                        fcnt_d     = '0;
                        buf_addr_d = w_next_c[BUF_AW-1:0];
                        data_d     = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    done_d = 1'b0;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            w_q        <= '0;
            fcnt_q     <= '0;
            cnt_q      <= '0;
            buf_addr_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            dma_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            n_q        <= n_d;
            w_q        <= w_d;
            fcnt_q     <= fcnt_d;
            cnt_q      <= cnt_d;
            buf_addr_q <= buf_addr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            dma_en_q   <= dma_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.bufAddr   = buf_addr_q;
    assign bus.dmaEnable = dma_en_q;
    assign bus.address   = addr_q;
    assign bus.dmaData   = data_q;
    assign bus.dmaCount  = cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_store_image.sv
// tb_store_image: scoreboard bench for store_image. Expected DMA blocks are built
// from the buffer contents when a transfer starts and checked as the DUT emits them.
module tb_store_image;
    localparam int unsigned AW  = 20;
    localparam int unsigned DW  = 16;
    localparam int unsigned BS  = 25;
    localparam int unsigned IW  = 6;
    localparam int unsigned DDW = BS * DW;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [4:0]     cnt;
        logic [DDW-1:0] data;
    } blk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_image_if #(.MEM_ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS),
                     .IMG_SIZE_WIDTH(IW)) bus ();

    store_image #(.MEM_ADDR_SIZE(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS),
                  .IMG_SIZE_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Feature-map buffer with one-cycle read latency
    logic [DW-1:0] mem [1024];
    always @(posedge clk) bus.bufData <= mem[bus.bufAddr];

    blk_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [DDW-1:0] act, input logic [DDW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int words(input int size);
        int n;
        n = size * size;
        if (n > 1024) n = 1024;
        return n;
    endfunction

    task automatic push_exp(input int size, input logic [AW-1:0] base);
        int n;
        int w;
        logic [AW-1:0] a;
        n = words(size);
        w = 0;
        a = base;
        while (w < n) begin
            blk_t e;
            int   c;
            c      = (n - w > int'(BS)) ? int'(BS) : n - w;
            e.addr = a;
            e.cnt  = 5'(c);
            e.data = '0;
            for (int k = 0; k < c; k++) e.data[k*DW +: DW] = mem[w + k];
            exp_q.push_back(e);
            w = w + c;
            a = a + AW'(BS);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dmaen"}, DDW'(bus.dmaEnable), 0);
        chk({tag, "_done"},  DDW'(bus.done), 0);
        chk({tag, "_busy"},  DDW'(bus.busy), 0);
        chk({tag, "_addr"},  DDW'(bus.address), 0);
        chk({tag, "_bufad"}, DDW'(bus.bufAddr), 0);
        chk({tag, "_cnt"},   DDW'(bus.dmaCount), 0);
        chk({tag, "_data"},  bus.dmaData, 0);
    endtask

    // One transfer; rst_blk>0 asserts reset while that block is being written
    task automatic run_xfer(input int size, input logic [AW-1:0] base, input int delay,
                            input bit spur, input int rst_blk);
        blk_t e;
        int   n;
        int   blk;
        int   budget;
        bit   fin;
        n      = words(size);
        blk    = 0;
        budget = 4000;
        fin    = 1'b0;
        push_exp(size, base);
        @(negedge clk);
        bus.enable      = 1'b1;
        bus.imgSize     = IW'(size);
        bus.initialAddr = base;
        @(negedge clk);
        chk("busy_start", DDW'(bus.busy), 1);
        if (n == 0) begin
            chk("zero_done", DDW'(bus.done), 1);
            chk("zero_dmaen", DDW'(bus.dmaEnable), 0);
        end
        while (!fin && budget > 0) begin
            budget--;
            // Start parameters must be ignored once running
            bus.imgSize     = IW'($urandom);
            bus.initialAddr = AW'($urandom);
            if (bus.done) begin
                fin = 1'b1;
            end else if (bus.dmaEnable) begin
                blk++;
                if (exp_q.size() == 0) begin
                    chk("extra_blk", 1, 0);
                    fin = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    chk("blk_addr", DDW'(bus.address), DDW'(e.addr));
                    chk("blk_cnt", DDW'(bus.dmaCount), DDW'(e.cnt));
                    chk("blk_data", bus.dmaData, e.data);
                    if (blk == rst_blk) begin
                        rst         = 1'b1;
                        bus.dmaAck  = 1'b1;
                        @(negedge clk);
                        chk_reset_vals("midrst");
                        exp_q.delete();
                        bus.dmaAck = 1'b0;
                        @(negedge clk);
                        chk("rst_hold_dmaen", DDW'(bus.dmaEnable), 0);
                        chk("rst_hold_busy", DDW'(bus.busy), 0);
                        rst        = 1'b0;
                        bus.enable = 1'b0;
                        repeat (3) @(negedge clk);
                        chk("post_rst_dmaen", DDW'(bus.dmaEnable), 0);
                        chk("post_rst_busy", DDW'(bus.busy), 0);
                        return;
                    end
                    for (int i = 0; i < delay; i++) begin
                        bus.dmaAck = 1'b0;
                        @(negedge clk);
                        chk("hold_en", DDW'(bus.dmaEnable), 1);
                        chk("hold_addr", DDW'(bus.address), DDW'(e.addr));
                        chk("hold_cnt", DDW'(bus.dmaCount), DDW'(e.cnt));
                        chk("hold_data", bus.dmaData, e.data);
                    end
                    bus.dmaAck = 1'b1;
                    @(negedge clk);
                    bus.dmaAck = 1'b0;
                    chk("ack_drop", DDW'(bus.dmaEnable), 0);
                end
            end else begin
                bus.dmaAck = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
        end
        bus.dmaAck = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        chk("end_done", DDW'(bus.done), 1);
        chk("end_busy", DDW'(bus.busy), 1);
        chk("end_dmaen", DDW'(bus.dmaEnable), 0);
        chk("sb_empty", DDW'(exp_q.size()), 0);
        if (n > 0) chk("bufaddr_hold", DDW'(bus.bufAddr), DDW'(n - 1));
        @(negedge clk);
        chk("done_hold", DDW'(bus.done), 1);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("idle_done", DDW'(bus.done), 0);
        chk("idle_busy", DDW'(bus.busy), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
        rst             = 1'b1;
        bus.enable      = 1'b0;
        bus.imgSize     = '0;
        bus.initialAddr = '0;
        bus.dmaAck      = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        run_xfer(5,  20'h00100, 0,  1'b0, 0);
        run_xfer(7,  20'h00000, 0,  1'b0, 0);
        run_xfer(0,  20'h00055, 0,  1'b0, 0);
        run_xfer(33, 20'hFFE00, 0,  1'b0, 0);
        run_xfer(6,  20'h02000, 10, 1'b1, 0);
        run_xfer(7,  20'h00000, 0,  1'b0, 2);
        run_xfer(7,  20'h00000, 0,  1'b1, 0);
        run_xfer(1,  20'h12345, 3,  1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/store_image.md
STORE_IMAGE -- requirements
Module: store_image

Interface
REQ-001 Param MEM_ADDR_SIZE, 20, external memory address width.
REQ-002 Param DATA_SIZE, 16, word width.
REQ-003 Param BLOCK_SIZE, 25, words per DMA write block.
REQ-004 Param IMG_SIZE_WIDTH, 6, image side-length width.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  start request, sampled only in IDLE.
REQ-008 imgSize  in  IMG_SIZE_WIDTH  image side length; sampled at start.
REQ-009 initialAddr  in  MEM_ADDR_SIZE  destination base address; sampled at start.
REQ-010 bufAddr  out  10  source feature-map buffer read address.
REQ-011 bufData  in  DATA_SIZE  buffer read data, valid one cycle after bufAddr.
REQ-012 dmaEnable  out  1  DMA write request.
REQ-013 dmaAck  in  1  DMA accepted current block.
REQ-014 address  out  MEM_ADDR_SIZE  destination address of current block.
REQ-015 dmaData  out  BLOCK_SIZE*DATA_SIZE  packed block; word i at bits [16i+15:16i].
REQ-016 dmaCount  out  5  valid words in current block, 1..25.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 done  out  1  transfer complete.

Function
REQ-019 Total words N = imgSize*imgSize computed at full 12-bit width, then clipped to 1024.
REQ-020 Block count = ceil(N/25); no extra trailing block; N=0 gives zero blocks.
REQ-021 FSM states IDLE, FETCH, WRITE, DONE; all outputs registered.
REQ-022 IDLE: on enable=1, latch N; latch address=initialAddr; word index w=0; go FETCH, or go DONE if N=0.
REQ-023 FETCH: cnt=min(25, N-w); drive bufAddr=w..w+cnt-1 on consecutive cycles; capture bufData into slot k one cycle after bufAddr; state lasts cnt+1 cycles.
REQ-024 FETCH clears all slots >= cnt to zero; dmaCount=cnt.
REQ-025 On FETCH exit, enter WRITE with dmaEnable=1 on the same edge.
REQ-026 WRITE: hold dmaEnable, address, dmaData and dmaCount stable until dmaAck is sampled high.
REQ-027 On dmaAck: dmaEnable=0 next cycle; address+=25 (wraps mod 2^MEM_ADDR_SIZE); w+=cnt; go FETCH if w<N, else DONE.
REQ-028 dmaAck outside WRITE is ignored.
REQ-029 DONE: done=1, busy=1; hold until enable=0, then go IDLE with done=0.
REQ-030 enable, imgSize and initialAddr changes after start are ignored until return to IDLE.
REQ-031 bufAddr holds its last value outside FETCH.

Reset
REQ-032 rst=1 at any edge forces IDLE with dmaEnable=0, done=0, busy=0, address=0, bufAddr=0, dmaCount=0, dmaData=0.
REQ-033 Reset mid-transfer abandons the in-flight block; no dmaEnable after the reset edge.
REQ-034 rst has priority over enable and dmaAck on the same edge.

Verification
REQ-035 imgSize=5, initialAddr=0x100, immediate ack -> one block: address=0x100, dmaCount=25, dmaData word i = buffer[i], then done=1.
REQ-036 imgSize=7, initialAddr=0 -> two blocks at 0 and 25, dmaCount 25 then 24, block-2 slot 24 = 0.
REQ-037 imgSize=0 -> DONE within 1 cycle of start, dmaEnable never asserted.
REQ-038 imgSize=33 -> N clipped to 1024; 41 blocks, last at initialAddr+1000 with dmaCount=24.
REQ-039 dmaAck delayed 10 cycles -> dmaEnable, address, dmaData stable for all 10 cycles; one advance per ack.
REQ-040 rst asserted during WRITE of block 2 (imgSize=7) -> next cycle all outputs at reset values; fresh start repeats from block 1.
